// File: rtl/s2_pkg.sv
// Shared types and constants for the S2 serial frame receiver.
// Frame layout: ADDR_W address bits followed by DATA_W data bits, MSB-first.
package s2_pkg;

    localparam int ADDR_W     = 3;
    localparam int DATA_W     = 18;
    localparam int NUM_FRAMES = 8;
    localparam int FRAME_LEN  = ADDR_W + DATA_W;

    localparam logic RB2_READ  = 1'b1;
    localparam logic RB2_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        WRITE   = 3'd2,
        WAIT_HI = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/s2_shift_reg.sv
// MSB-first serial-in/parallel-out frame register with shift enable and clear.
// The first bit shifted in ends up in the top of the address field.
module s2_shift_reg #(
    parameter int ADDR_W = s2_pkg::ADDR_W,
    parameter int DATA_W = s2_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              din,
    output logic [ADDR_W-1:0] addr_field,
    output logic [DATA_W-1:0] data_field
);

    localparam int LEN = ADDR_W + DATA_W;

    logic [LEN-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[LEN-2:0], din};
        end
    end

    assign addr_field = q[LEN-1 -: ADDR_W];
    assign data_field = q[DATA_W-1:0];

endmodule

// File: rtl/s2_rx.sv
// Serial frame receiver: deserializes sen/sd frames and writes each data word
// into the RB2 register bank at the frame's address; done after NUM_FRAMES writes.
//
// state   | meaning
// IDLE    | waiting for sen low; first low edge samples bit 0
// SHIFT   | collecting bits 1..FRAME_LEN-1; sen high aborts the frame
// WRITE   | frame complete; RB2 write strobe is registered out next cycle
// WAIT_HI | swallowing extra bits until sen returns high
// DONE    | NUM_FRAMES written; link ignored until reset
module s2_rx #(
    parameter int ADDR_W     = s2_pkg::ADDR_W,
    parameter int DATA_W     = s2_pkg::DATA_W,
    parameter int NUM_FRAMES = s2_pkg::NUM_FRAMES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sen,
    input  logic              sd,
    output logic              RB2_RW,
    output logic [ADDR_W-1:0] RB2_A,
    output logic [DATA_W-1:0] RB2_D,
    input  logic [DATA_W-1:0] RB2_Q,
    output logic              done
);

    import s2_pkg::*;

    localparam int LEN    = ADDR_W + DATA_W;
    localparam int CNT_W  = $clog2(LEN + 1);
    localparam int FCNT_W = $clog2(NUM_FRAMES + 1);

    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(LEN - 1);
    localparam logic [FCNT_W-1:0] LAST_FRAME = FCNT_W'(NUM_FRAMES - 1);

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]  bit_cnt;
    logic [FCNT_W-1:0] frm_cnt;

    logic              sh_en;
    logic              sh_clr;
    logic [ADDR_W-1:0] addr_field;
    logic [DATA_W-1:0] data_field;

    logic              rw_nxt;
    logic [ADDR_W-1:0] a_nxt;
    logic [DATA_W-1:0] d_nxt;
    logic              done_nxt;

    // Read data is never consumed by the receiver.
    logic unused_q;
    assign unused_q = ^RB2_Q;

    s2_shift_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .clr        (sh_clr),
        .en         (sh_en),
        .din        (sd),
        .addr_field (addr_field),
        .data_field (data_field)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!sen) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (sen)                   state_nxt = IDLE;
                else if (bit_cnt == LAST_BIT) state_nxt = WRITE;
            end
            WRITE: begin
                // A single sen-high cycle right after the last bit lands here,
                // so it must already count as the inter-frame gap.
                if (frm_cnt == LAST_FRAME) state_nxt = DONE;
                else if (sen)              state_nxt = IDLE;
                else                       state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (sen) state_nxt = IDLE;
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        sh_en  = 1'b0;
        sh_clr = 1'b0;
        if (state == IDLE || state == SHIFT) begin
            sh_en  = !sen;
            sh_clr = sen;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (state == IDLE && !sen) begin
            bit_cnt <= CNT_W'(1);
        end else if (state == SHIFT && !sen) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end else begin
            bit_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_cnt <= '0;
        end else if (state == WRITE) begin
            frm_cnt <= frm_cnt + FCNT_W'(1);
        end
    end

    always_comb begin
        rw_nxt   = RB2_READ;
        a_nxt    = RB2_A;
        d_nxt    = RB2_D;
        done_nxt = done;
        if (state == WRITE) begin
            rw_nxt = RB2_WRITE;
            a_nxt  = addr_field;
            d_nxt  = data_field;
        end
        if (state == DONE) begin
            done_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RB2_RW <= RB2_READ;
            RB2_A  <= '0;
            RB2_D  <= '0;
            done   <= 1'b0;
        end else begin
            RB2_RW <= rw_nxt;
            RB2_A  <= a_nxt;
            RB2_D  <= d_nxt;
            done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_s2_rx.sv
// Directed bench for s2_rx: drives sen/sd frames and checks the RB2 write
// strobes, their timing and the done flag against hand-computed values.
module tb_s2_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        sen;
    logic        sd;
    logic        RB2_RW;
    logic [2:0]  RB2_A;
    logic [17:0] RB2_D;
    logic [17:0] RB2_Q;
    logic        done;

    typedef struct {
        logic [2:0]  a;
        logic [17:0] d;
        int          cyc;
    } wr_t;

    wr_t wq[$];
    int  cyc = 0;
    int  bit20_cyc = 0;
    int  done_cyc = -1;
    int  total = 0;
    int  bad = 0;

    s2_rx dut (
        .clk    (clk),
        .rst    (rst),
        .sen    (sen),
        .sd     (sd),
        .RB2_RW (RB2_RW),
        .RB2_A  (RB2_A),
        .RB2_D  (RB2_D),
        .RB2_Q  (RB2_Q),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle with a write strobe, and the first cycle done is high.
    always @(negedge clk) begin
        if (RB2_RW === 1'b0) wq.push_back('{RB2_A, RB2_D, cyc});
        if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    end

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sen = 1'b1;
            sd  = 1'bx;
        end
    endtask

    task automatic send_frame(input logic [2:0] a, input logic [17:0] d,
                              input int nlow, input int ngap);
        logic [20:0] w;
        w = {a, d};
        for (int i = 0; i < nlow; i++) begin
            @(negedge clk);
            sen = 1'b0;
            sd  = (i < 21) ? w[20 - i] : 1'($urandom_range(0, 1));
            if (i == 20) bit20_cyc = cyc;
        end
        drive_idle(ngap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sen = 1'b1;
        sd  = 1'bx;
        @(negedge clk);
        rst = 1'b0;
        wq.delete();
        done_cyc = -1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (RB2_RW !== 1'b1) begin bad++; $display("FAIL reset_rw got=%b exp=1", RB2_RW); end
        total++; if (RB2_A !== 3'd0) begin bad++; $display("FAIL reset_a got=%0d exp=0", RB2_A); end
        total++; if (RB2_D !== 18'h0) begin bad++; $display("FAIL reset_d got=%h exp=0", RB2_D); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        send_frame(3'b101, 18'h2A5C3, 21, 4);
        drive_idle(3);
        total++; if (wq.size() !== 1) begin bad++; $display("FAIL single_count got=%0d exp=1", wq.size()); end
        if (wq.size() >= 1) begin
            total++; if (wq[0].a !== 3'd5) begin bad++; $display("FAIL single_a got=%0d exp=5", wq[0].a); end
            total++; if (wq[0].d !== 18'h2A5C3) begin bad++; $display("FAIL single_d got=%h exp=2a5c3", wq[0].d); end
            total++; if (wq[0].cyc !== bit20_cyc + 2) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", wq[0].cyc, bit20_cyc + 2); end
        end
        total++; if (RB2_RW !== 1'b1) begin bad++; $display("FAIL single_rw_idle got=%b exp=1", RB2_RW); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL single_done got=%b exp=0", done); end
    endtask

    task automatic test_back_to_back();
        int last_b20;
        do_reset();
        for (int a = 0; a < 8; a++) begin
            send_frame(3'(a), 18'h00001 << a, 21, 1);
        end
        last_b20 = bit20_cyc;
        drive_idle(4);
        total++; if (wq.size() !== 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", wq.size()); end
        for (int i = 0; i < 8 && i < wq.size(); i++) begin
            total++; if (wq[i].a !== 3'(i)) begin bad++; $display("FAIL b2b_a[%0d] got=%0d exp=%0d", i, wq[i].a, i); end
            total++; if (wq[i].d !== (18'h00001 << i)) begin bad++; $display("FAIL b2b_d[%0d] got=%h exp=%h", i, wq[i].d, 18'h00001 << i); end
        end
        if (wq.size() == 8) begin
            total++; if (wq[7].cyc !== last_b20 + 2) begin bad++; $display("FAIL b2b_last_latency got=%0d exp=%0d", wq[7].cyc, last_b20 + 2); end
        end
        total++; if (done_cyc !== last_b20 + 3) begin bad++; $display("FAIL b2b_done_rise got=%0d exp=%0d", done_cyc, last_b20 + 3); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done_hold got=%b exp=1", done); end
    endtask

    task automatic test_after_done();
        send_frame(3'd0, 18'h3FFFF, 21, 2);
        drive_idle(3);
        total++; if (wq.size() !== 8) begin bad++; $display("FAIL after_done_writes got=%0d exp=8", wq.size()); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL after_done_done got=%b exp=1", done); end
        total++; if (RB2_RW !== 1'b1) begin bad++; $display("FAIL after_done_rw got=%b exp=1", RB2_RW); end
    endtask

    task automatic test_abort();
        do_reset();
        send_frame(3'b011, 18'h15555, 10, 1);
        send_frame(3'd2, 18'h3FFFF, 21, 2);
        drive_idle(3);
        total++; if (wq.size() !== 1) begin bad++; $display("FAIL abort_count got=%0d exp=1", wq.size()); end
        if (wq.size() >= 1) begin
            total++; if (wq[0].a !== 3'd2) begin bad++; $display("FAIL abort_a got=%0d exp=2", wq[0].a); end
            total++; if (wq[0].d !== 18'h3FFFF) begin bad++; $display("FAIL abort_d got=%h exp=3ffff", wq[0].d); end
        end
        total++; if (dut.frm_cnt !== 4'd1) begin bad++; $display("FAIL abort_frame_cnt got=%0d exp=1", dut.frm_cnt); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
    endtask

    task automatic test_overlong();
        wq.delete();
        send_frame(3'd1, 18'h12345, 25, 1);
        send_frame(3'd4, 18'h0F0F0, 21, 2);
        drive_idle(3);
        total++; if (wq.size() !== 2) begin bad++; $display("FAIL long_count got=%0d exp=2", wq.size()); end
        if (wq.size() >= 2) begin
            total++; if (wq[0].a !== 3'd1) begin bad++; $display("FAIL long_a got=%0d exp=1", wq[0].a); end
            total++; if (wq[0].d !== 18'h12345) begin bad++; $display("FAIL long_d got=%h exp=12345", wq[0].d); end
            total++; if (wq[1].a !== 3'd4) begin bad++; $display("FAIL long_next_a got=%0d exp=4", wq[1].a); end
            total++; if (wq[1].d !== 18'h0F0F0) begin bad++; $display("FAIL long_next_d got=%h exp=0f0f0", wq[1].d); end
        end
    endtask

    task automatic test_reset_mid();
        wq.delete();
        send_frame(3'd3, 18'h11111, 12, 0);
        @(negedge clk);
        rst = 1'b1;
        sd  = 1'b1;
        @(negedge clk);
        total++; if (RB2_RW !== 1'b1) begin bad++; $display("FAIL midrst_rw got=%b exp=1", RB2_RW); end
        total++; if (RB2_A !== 3'd0) begin bad++; $display("FAIL midrst_a got=%0d exp=0", RB2_A); end
        total++; if (RB2_D !== 18'h0) begin bad++; $display("FAIL midrst_d got=%h exp=0", RB2_D); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", done); end
        rst = 1'b0;
        sen = 1'b1;
        sd  = 1'bx;
        drive_idle(2);
        send_frame(3'd6, 18'h0ABCD, 21, 2);
        drive_idle(3);
        total++; if (wq.size() !== 1) begin bad++; $display("FAIL midrst_count got=%0d exp=1", wq.size()); end
        if (wq.size() >= 1) begin
            total++; if (wq[0].a !== 3'd6) begin bad++; $display("FAIL midrst_wa got=%0d exp=6", wq[0].a); end
            total++; if (wq[0].d !== 18'h0ABCD) begin bad++; $display("FAIL midrst_wd got=%h exp=0abcd", wq[0].d); end
        end
        total++; if (dut.frm_cnt !== 4'd1) begin bad++; $display("FAIL midrst_frame_cnt got=%0d exp=1", dut.frm_cnt); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done_after got=%b exp=0", done); end
    endtask

    initial begin
        rst   = 1'b1;
        sen   = 1'b1;
        sd    = 1'bx;
        RB2_Q = 18'h0;
        test_reset();
        test_single();
        test_abort();
        test_overlong();
        test_reset_mid();
        test_back_to_back();
        test_after_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
